// File: rtl/rr_select_4_1.sv
// Four-lane round-robin selector feeding one registered output slot with valid/ready handshakes.
// Define RR_SELECT_FIXED_PRIO_EN to freeze the search pointer at lane 0, giving fixed priority with lane 0 highest.
module rr_select_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [1:0]       ptr;
  logic [1:0]       gnt;
  logic [1:0]       idx;
  logic             found;
  logic             load;
  logic [WIDTH-1:0] gnt_data;

  // Search from ptr upward; when no lane is valid the grant rests on ptr.
  always_comb begin
    gnt   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  assign sel  = gnt;
  assign load = (|in_valid) & (~out_valid | out_ready);

  always_comb begin
    in_ready = 4'b0000;
    if (load && rst_n) in_ready[gnt] = 1'b1;
  end

  // Only the granted lane is read, so non-granted lanes may carry X.
  always_comb begin
    case (gnt)
      2'd0:    gnt_data = d0;
      2'd1:    gnt_data = d1;
      2'd2:    gnt_data = d2;
      default: gnt_data = d3;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd0;
    end else begin
`ifdef RR_SELECT_FIXED_PRIO_EN
      ptr <= 2'd0;
`else
      if (load) ptr <= gnt + 2'd1;
`endif
    end
  end

endmodule

// File: tb/tb_rr_select_4_1.sv
// Directed bench for rr_select_4_1 (default round-robin build) with a scoreboard queue of expected output words.
module tb_rr_select_4_1;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  int n_chk = 0;
  int n_err = 0;
  logic [WIDTH-1:0] sb_q[$];

  rr_select_4_1 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepting cycle: drive, check the combinational grant, push the expected word, then pop it after the edge.
  task automatic cyc(input string tag, input logic [3:0] v, input logic ordy,
                     input logic [3:0] exp_rdy, input logic [1:0] exp_sel,
                     input logic [WIDTH-1:0] exp_word);
    logic [WIDTH-1:0] w;
    in_valid  = v;
    out_ready = ordy;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
    chk({tag, "_sel"}, 32'(sel), 32'(exp_sel));
    if (exp_rdy != 4'b0000) sb_q.push_back(exp_word);
    tick();
    if (sb_q.size() > 0) begin
      w = sb_q.pop_front();
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_out_data"}, 32'(out_data), 32'(w));
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 4'b0000; out_ready = 1'b0;
    d0 = 4'ha; d1 = 4'hb; d2 = 4'hc; d3 = 4'hd;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 4'b1111;
    #1;
    chk("rst_in_ready_valid", 32'(in_ready), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;

    // Round-robin over four valid lanes with full throughput.
    cyc("rr0", 4'b1111, 1'b1, 4'b0001, 2'd0, 4'ha);
    cyc("rr1", 4'b1111, 1'b1, 4'b0010, 2'd1, 4'hb);
    cyc("rr2", 4'b1111, 1'b1, 4'b0100, 2'd2, 4'hc);
    cyc("rr3", 4'b1111, 1'b1, 4'b1000, 2'd3, 4'hd);
    cyc("rr4", 4'b1111, 1'b1, 4'b0001, 2'd0, 4'ha);

    // Idle drain: ptr rests at 1.
    in_valid = 4'b0000; out_ready = 1'b1;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    chk("idle_sel", 32'(sel), 32'd1);
    tick();
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // Single word 3 on lane 2, then drain.
    d2 = 4'h3;
    cyc("drain_load", 4'b0100, 1'b1, 4'b0100, 2'd2, 4'h3);
    in_valid = 4'b0000;
    tick();
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_out_data", 32'(out_data), 32'h3);

    // ptr=3, lanes 0 and 2 valid: wrap to lane 0, then lane 2.
    cyc("wrap0", 4'b0101, 1'b1, 4'b0001, 2'd0, 4'ha);
    cyc("wrap1", 4'b0101, 1'b1, 4'b0100, 2'd2, 4'h3);

    // Backpressure: hold 7 while lane 1 waits.
    d3 = 4'h7;
    cyc("bp_load", 4'b1000, 1'b1, 4'b1000, 2'd3, 4'h7);
    for (int i = 0; i < 3; i++) begin
      in_valid = 4'b0010; out_ready = 1'b0;
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_sel", 32'(sel), 32'd1);
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'h7);
    end
    cyc("bp_release", 4'b0010, 1'b1, 4'b0010, 2'd1, 4'hb);

    // Non-granted lanes carry X; ptr=2, only lane 1 valid.
    d0 = 'x; d3 = 'x;
    cyc("xlane", 4'b0010, 1'b1, 4'b0010, 2'd1, 4'hb);

    // Reset mid-stream while holding 5.
    d0 = 4'ha; d2 = 4'h5;
    cyc("hold5", 4'b0100, 1'b1, 4'b0100, 2'd2, 4'h5);
    out_ready = 1'b0; in_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out_data", 32'(out_data), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    chk("mrst_sel", 32'(sel), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    cyc("post_rst", 4'b1111, 1'b1, 4'b0001, 2'd0, 4'ha);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
